// File: rtl/ysyx_25040111_ifetch_axi_if.sv
// AXI4-Lite read-only instruction port: AR and R channels between the fetch master and the memory slave.
interface ysyx_25040111_ifetch_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [2:0]        arprot;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, arprot, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, arprot, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_25040111_ifetch_axi.sv
// Instruction-fetch bus master: one AXI4-Lite read per start pulse.
// Returns the word with a one-cycle if_ok strobe, flags misaligned PCs and
// bus errors, and reports the latency of the last completed fetch.
module ysyx_25040111_ifetch_axi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst_t,
  output logic              if_ok,
  output logic              fetch_err,
  output logic [1:0]        err_cause,
  output logic              busy,
  output logic [15:0]       lat_cnt,
  ysyx_25040111_ifetch_axi_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FAULT} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        accept, aligned, ar_hs, r_hs, r_err;

  // Unprivileged, secure, instruction access.
  assign bus.arprot = 3'b100;

  assign busy    = (state != IDLE);
  assign accept  = (state == IDLE) && start;
  assign aligned = (pc[1:0] == 2'b00);
  assign ar_hs   = (state == ADDR) && bus.arvalid && bus.arready;
  // R beats are only honoured while a read is outstanding.
  assign r_hs    = (state == DATA) && bus.rvalid && bus.rready;
  assign r_err   = bus.rresp[1];
  // The reported latency includes the completing cycle itself.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = aligned ? ADDR : FAULT;
      ADDR:    if (ar_hs) state_nxt = DATA;
      DATA:    if (r_hs)  state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus handshakes, completion outputs and the latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.araddr  <= '0;
      bus.arvalid <= 1'b0;
      bus.rready  <= 1'b0;
      inst_t      <= '0;
      if_ok       <= 1'b0;
      fetch_err   <= 1'b0;
      err_cause   <= 2'b00;
      lat_cnt     <= 16'd0;
      cnt         <= 16'd0;
    end else begin
      if_ok <= 1'b0;
      if (accept)    cnt <= 16'd1;
      else if (busy) cnt <= cnt_inc;
      case (state)
        IDLE: begin
          if (accept && aligned) begin
            bus.araddr  <= pc;
            bus.arvalid <= 1'b1;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
          end
        end
        DATA: begin
          if (r_hs) begin
            bus.rready <= 1'b0;
            if_ok      <= 1'b1;
            lat_cnt    <= cnt_inc;
            // EXOKAY is treated as OKAY; SLVERR/DECERR carry their code.
            inst_t     <= r_err ? '0 : bus.rdata;
            fetch_err  <= r_err;
            err_cause  <= r_err ? bus.rresp : 2'b00;
          end
        end
        FAULT: begin
          if_ok     <= 1'b1;
          fetch_err <= 1'b1;
          err_cause <= 2'b01;
          inst_t    <= '0;
          lat_cnt   <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_ifetch_axi.sv
// Randomized bench for the instruction-fetch AXI master with a cycle-level slave
// and a latency/result model derived from the stall counts and response codes.
module tb_ysyx_25040111_ifetch_axi;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic [31:0] inst_t;
  logic        if_ok;
  logic        fetch_err;
  logic [1:0]  err_cause;
  logic        busy;
  logic [15:0] lat_cnt;

  ysyx_25040111_ifetch_axi_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_25040111_ifetch_axi #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .inst_t(inst_t), .if_ok(if_ok), .fetch_err(fetch_err),
    .err_cause(err_cause), .busy(busy), .lat_cnt(lat_cnt),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Values that must hold between completions.
  logic [31:0] h_inst;
  logic        h_err;
  logic [1:0]  h_cause;
  logic [15:0] h_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller has already driven start=1/pc=addr at a negedge. Returns at the
  // negedge of the expected if_ok cycle with start low.
  task automatic fetch(input logic [31:0] addr, input int ar_d, input int r_d,
                       input logic [1:0] resp, input logic [31:0] data);
    int arw = 0;
    int rw  = 0;
    int hs  = 0;
    int exp_lat;
    bit al;
    bit done = 0;
    logic [31:0] e_inst;
    logic        e_err;
    logic [1:0]  e_cause;
    al      = (addr[1:0] == 2'b00);
    exp_lat = al ? 3 + ar_d + r_d : 2;
    if (!al)             begin e_inst = 0;    e_err = 1; e_cause = 2'b01; end
    else if (resp[1])    begin e_inst = 0;    e_err = 1; e_cause = resp;  end
    else                 begin e_inst = data; e_err = 0; e_cause = 2'b00; end
    @(posedge clk);
    for (int k = 1; k <= exp_lat && !done; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) begin
        chk("arvalid_first", bus.arvalid, al);
        chk("inst_hold", inst_t, h_inst);
        chk("err_hold", fetch_err, h_err);
        chk("cause_hold", err_cause, h_cause);
        chk("lat_hold", lat_cnt, h_lat);
      end
      if (!al) chk("arvalid_mis", bus.arvalid, 0);
      if (bus.arvalid) chk("araddr", bus.araddr, addr);
      chk("busy", busy, k < exp_lat);
      chk("if_ok", if_ok, k == exp_lat);
      if (k == exp_lat) begin
        chk("inst", inst_t, e_inst);
        chk("fetch_err", fetch_err, e_err);
        chk("err_cause", err_cause, e_cause);
        chk("lat_cnt", lat_cnt, exp_lat);
        chk("ar_hs_cnt", hs, al);
        chk("rready_done", bus.rready, 0);
        h_inst = e_inst; h_err = e_err; h_cause = e_cause; h_lat = exp_lat[15:0];
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        done = 1;
      end else begin
        if (bus.arvalid) begin
          if (arw == ar_d) begin bus.arready = 1'b1; hs++; end
          else begin bus.arready = 1'b0; arw++; end
        end else begin
          bus.arready = 1'($urandom % 2);
        end
        if (bus.rready) begin
          if (rw == r_d) begin
            bus.rvalid = 1'b1; bus.rdata = data; bus.rresp = resp;
          end else begin
            bus.rvalid = 1'b0; bus.rdata = $urandom; bus.rresp = 2'($urandom); rw++;
          end
        end else begin
          // Stray R beats outside the data phase must be ignored.
          bus.rvalid = 1'($urandom % 2); bus.rdata = $urandom; bus.rresp = 2'($urandom);
        end
        // Starts while busy must be ignored.
        start = (k == 1) || ($urandom % 3 == 0);
        pc    = $urandom;
      end
    end
  endtask

  task automatic go(input logic [31:0] addr, input int ar_d, input int r_d,
                    input logic [1:0] resp, input logic [31:0] data);
    start = 1'b1;
    pc    = addr;
    fetch(addr, ar_d, r_d, resp, data);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_if_ok", if_ok, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; start = 1'b0; pc = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    h_inst = 0; h_err = 0; h_cause = 0; h_lat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_if_ok", if_ok, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inst", inst_t, 0);
    chk("rst_lat", lat_cnt, 0);
    chk("arprot", bus.arprot, 3'b100);
    reset = 1'b0;
    idle_gap(2);

    // Directed cases; consecutive go() calls are back-to-back fetches.
    go(32'h8000_0000, 0, 0, 2'b00, 32'h0000_0413);
    idle_gap(1);
    go(32'h8000_0004, 2, 3, 2'b00, 32'h1234_5678);
    go(32'h8000_0008, 0, 0, 2'b11, 32'hDEAD_BEEF);
    go(32'h8000_000C, 1, 0, 2'b10, 32'hCAFE_F00D);
    go(32'h8000_0002, 0, 0, 2'b00, 32'h0);
    go(32'h8000_0010, 0, 1, 2'b01, 32'h0000_0093);
    idle_gap(2);

    // Reset while waiting for the R beat.
    start = 1'b1; pc = 32'h8000_0100;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    chk("pre_rst_rready", bus.rready, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_arvalid", bus.arvalid, 0);
    chk("mid_rst_rready", bus.rready, 0);
    chk("mid_rst_if_ok", if_ok, 0);
    chk("mid_rst_err", fetch_err, 0);
    chk("mid_rst_cause", err_cause, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_inst", inst_t, 0);
    chk("mid_rst_araddr", bus.araddr, 0);
    chk("mid_rst_lat", lat_cnt, 0);
    reset = 1'b0;
    h_inst = 0; h_err = 0; h_cause = 0; h_lat = 0;
    idle_gap(1);
    go(32'h8000_0200, 0, 0, 2'b00, 32'h0050_0513);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom % 5 != 0) a[1:0] = 2'b00;
      else if (a[1:0] == 2'b00) a[0] = 1'b1;
      idle_gap($urandom_range(0, 2));
      go(a, $urandom_range(0, 4), $urandom_range(0, 4), 2'($urandom), $urandom);
    end
    idle_gap(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
